edac_decoder: RTL and testbench

Receive-side companion of the EDAC encoder: it accepts a 32-bit protected word, runs Hamming(21,16) single-error correction, then recomputes the 8-bit CRC bit-serially and flags any mismatch. It sits between the boosted I/O path or memory read port and the DLX core. The output is the 8-bit payload plus error status, moved through valid/ready handshakes on both sides.

---
 rtl/edac_decoder.sv | 194 +++++++++++++++++++
 tb/tb_edac_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/edac_decoder.sv
// edac_decoder
//   Receive-side EDAC check. It accepts a 21-bit Hamming(21,16) codeword
//   (carried in Din[20:0]) and corrects a single-bit error. It then recomputes
//   the 8-bit CRC of the payload, one division step per cycle, and compares it
//   with the received CRC field.
// Ports
//   clk, rst             : rising-edge clock, async active-high reset
//   Din[31:0], CRC_POLY  : received word and CRC divisor, both sampled on accept
//   in_valid / in_ready  : input handshake (ready only in IDLE)
//   out_valid / out_ready: output handshake (valid only in DONE)
//   Dout                 : recovered payload I[15:8]
//   err_pos              : 1-based corrected position, 0 if none
//   corrected            : a single-bit error was corrected
//   uncorrectable        : syndrome pointed outside the codeword
//   crc_err              : recomputed CRC differs from the received field
//   corr_count           : saturating count of corrected words
module edac_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Din,
   input  logic [7:0]  CRC_POLY,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [7:0]  Dout,
   output logic [4:0]  err_pos,
   output logic        corrected,
   output logic        uncorrectable,
   output logic        crc_err,
   output logic [15:0] corr_count
);

   typedef enum logic [1:0] {IDLE, CORRECT, CRC, DONE} state_t;

   state_t      state_q, state_d;
   logic [20:0] word_q, word_d;
   logic [7:0]  poly_q, poly_d;
   logic [15:0] t_q, t_d;
   logic [3:0]  step_q, step_d;
   logic [7:0]  crc_field_q, crc_field_d;
   logic [7:0]  payload_q, payload_d;
   logic [4:0]  pos_q, pos_d;
   logic        corr_q, corr_d;
   logic        unc_q, unc_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  dout_q, dout_d;
   logic [4:0]  err_pos_q, err_pos_d;
   logic        corrected_q, corrected_d;
   logic        uncorrectable_q, uncorrectable_d;
   logic        crc_err_q, crc_err_d;
   logic [15:0] corr_count_q, corr_count_d;

   logic [4:0]  syn;
   logic        fix;
   logic [20:0] fixed;
   logic [15:0] info;
   logic [3:0]  k;

   // Syndrome, correction and data extraction work on the latched word
   always_comb begin
      syn = 5'd0;
      for (int i = 0; i < 21; i++)
         if (word_q[i]) syn = syn ^ 5'(i + 1);
      fix = (syn != 5'd0) && (syn <= 5'd21);
      for (int i = 0; i < 21; i++)
         fixed[i] = word_q[i] ^ (fix && (syn == 5'(i + 1)));
      // Data bits skip the power-of-two (parity) positions
      info = {fixed[20:16], fixed[14:8], fixed[6:4], fixed[2]};
   end

   always_comb begin
      state_d         = state_q;
      word_d          = word_q;
      poly_d          = poly_q;
      t_d             = t_q;
      step_d          = step_q;
      crc_field_d     = crc_field_q;
      payload_d       = payload_q;
      pos_d           = pos_q;
      corr_d          = corr_q;
      unc_d           = unc_q;
      in_ready_d      = in_ready_q;
      out_valid_d     = out_valid_q;
      dout_d          = dout_q;
      err_pos_d       = err_pos_q;
      corrected_d     = corrected_q;
      uncorrectable_d = uncorrectable_q;
      crc_err_d       = crc_err_q;
      corr_count_d    = corr_count_q;
      k               = 4'(4'd15 - step_q);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               word_d     = Din[20:0];
               poly_d     = CRC_POLY;
               in_ready_d = 1'b0;
               state_d    = CORRECT;
            end
         end
         CORRECT: begin
            corr_d      = fix;
            unc_d       = syn > 5'd21;
            pos_d       = fix ? syn : 5'd0;
            t_d         = {info[15:8], 8'h00};
            payload_d   = info[15:8];
            crc_field_d = info[7:0];
            step_d      = 4'd0;
            if (fix && corr_count_q != 16'hFFFF)
               corr_count_d = corr_count_q + 16'd1;
            state_d     = CRC;
         end
         CRC: begin
            if (step_q != 4'd8) begin
               // Step j reduces bit 15-j with the divisor aligned so its LSB sits at bit 8-j
               if (t_q[k])
                  t_d = t_q ^ ({8'h00, poly_q} << (4'd8 - step_q));
               step_d = step_q + 4'd1;
            end else begin
               // All 8 steps done: publish the result in one edge
               dout_d          = payload_q;
               err_pos_d       = pos_q;
               corrected_d     = corr_q;
               uncorrectable_d = unc_q;
               crc_err_d       = t_q[7:0] != crc_field_q;
               out_valid_d     = 1'b1;
               state_d         = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         word_q          <= '0;
         poly_q          <= '0;
         t_q             <= '0;
         step_q          <= '0;
         crc_field_q     <= '0;
         payload_q       <= '0;
         pos_q           <= '0;
         corr_q          <= 1'b0;
         unc_q           <= 1'b0;
         in_ready_q      <= 1'b1;
         out_valid_q     <= 1'b0;
         dout_q          <= '0;
         err_pos_q       <= '0;
         corrected_q     <= 1'b0;
         uncorrectable_q <= 1'b0;
         crc_err_q       <= 1'b0;
         corr_count_q    <= '0;
      end else begin
         state_q         <= state_d;
         word_q          <= word_d;
         poly_q          <= poly_d;
         t_q             <= t_d;
         step_q          <= step_d;
         crc_field_q     <= crc_field_d;
         payload_q       <= payload_d;
         pos_q           <= pos_d;
         corr_q          <= corr_d;
         unc_q           <= unc_d;
         in_ready_q      <= in_ready_d;
         out_valid_q     <= out_valid_d;
         dout_q          <= dout_d;
         err_pos_q       <= err_pos_d;
         corrected_q     <= corrected_d;
         uncorrectable_q <= uncorrectable_d;
         crc_err_q       <= crc_err_d;
         corr_count_q    <= corr_count_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign Dout          = dout_q;
   assign err_pos       = err_pos_q;
   assign corrected     = corrected_q;
   assign uncorrectable = uncorrectable_q;
   assign crc_err       = crc_err_q;
   assign corr_count    = corr_count_q;

endmodule

// File: tb/tb_edac_decoder.sv
// Bench for edac_decoder: directed words from the test plan plus random
// codewords, checked against a behavioural decode model.
module tb_edac_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Din;
   logic [7:0]  CRC_POLY;
   logic        in_valid, in_ready, out_ready, out_valid;
   logic [7:0]  Dout;
   logic [4:0]  err_pos;
   logic        corrected, uncorrectable, crc_err;
   logic [15:0] corr_count;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   // Hamming positions (0-based index) of data bits I[0]..I[15]
   int dpos [16] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 16, 17, 18, 19, 20};

   edac_decoder dut (
      .clk(clk), .rst(rst), .Din(Din), .CRC_POLY(CRC_POLY),
      .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
      .out_valid(out_valid), .Dout(Dout), .err_pos(err_pos),
      .corrected(corrected), .uncorrectable(uncorrectable),
      .crc_err(crc_err), .corr_count(corr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [31:0] din, input logic [7:0] poly,
                                 output logic [7:0] dout, output logic [4:0] pos,
                                 output logic corr, output logic unc, output logic cerr);
      int s = 0;
      logic [20:0] w = din[20:0];
      logic [15:0] d;
      logic [15:0] t;
      for (int p = 1; p <= 21; p++) if (w[p-1]) s = s ^ p;
      corr = (s >= 1 && s <= 21);
      unc  = (s > 21);
      pos  = corr ? 5'(s) : 5'd0;
      if (corr) w[s-1] = ~w[s-1];
      for (int j = 0; j < 16; j++) d[j] = w[dpos[j]];
      t = {d[15:8], 8'h00};
      for (int kk = 15; kk >= 8; kk--)
         if (t[kk]) t = t ^ (16'(poly) << (kk - 7));
      dout = d[15:8];
      cerr = (t[7:0] != d[7:0]);
   endfunction

   // Builds a valid codeword from 16 data bits by solving for the parity bits
   function automatic logic [31:0] encode(input logic [15:0] d);
      logic [31:0] w = '0;
      int s = 0;
      for (int j = 0; j < 16; j++) if (d[j]) begin
         w[dpos[j]] = 1'b1;
         s = s ^ (dpos[j] + 1);
      end
      for (int b = 0; b < 5; b++) if (s[b]) w[(1 << b) - 1] = 1'b1;
      return w;
   endfunction

   task automatic check_outputs(input string tag, input logic [31:0] din, input logic [7:0] poly);
      logic [7:0] ed;
      logic [4:0] ep;
      logic ec, eu, ee;
      model(din, poly, ed, ep, ec, eu, ee);
      chk({tag, ".dout"}, 32'(Dout), 32'(ed));
      chk({tag, ".pos"},  32'(err_pos), 32'(ep));
      chk({tag, ".corr"}, 32'(corrected), 32'(ec));
      chk({tag, ".unc"},  32'(uncorrectable), 32'(eu));
      chk({tag, ".crc"},  32'(crc_err), 32'(ee));
      chk({tag, ".cnt"},  32'(corr_count), 32'(exp_cnt));
   endtask

   task automatic xfer(input string tag, input logic [31:0] din, input logic [7:0] poly, input int bp);
      int lat;
      logic [7:0] ed;
      logic [4:0] ep;
      logic ec, eu, ee;
      model(din, poly, ed, ep, ec, eu, ee);
      @(negedge clk);
      Din = din; CRC_POLY = poly; in_valid = 1'b1; out_ready = 1'b0;
      chk({tag, ".rdy_idle"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; Din = $urandom; CRC_POLY = 8'($urandom);
      if (ec && exp_cnt != 65535) exp_cnt++;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'd10);
      check_outputs(tag, din, poly);
      for (int c = 0; c < bp; c++) begin
         @(posedge clk); #1;
         chk({tag, ".bp_vld"}, 32'(out_valid), 32'd1);
         chk({tag, ".bp_rdy"}, 32'(in_ready), 32'd0);
         chk({tag, ".bp_dout"}, 32'(Dout), 32'(ed));
         chk({tag, ".bp_crc"}, 32'(crc_err), 32'(ee));
      end
      // Output handshake with in_valid also high: only the output side may complete
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      chk({tag, ".vld_drop"}, 32'(out_valid), 32'd0);
      chk({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
      // Previous status persists through IDLE
      check_outputs({tag, ".hold"}, din, poly);
   endtask

   initial begin
      int aborted;
      logic [15:0] d;
      logic [31:0] w;
      rst = 1'b1; Din = '0; CRC_POLY = '0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.rdy", 32'(in_ready), 32'd1);
      chk("rst.vld", 32'(out_valid), 32'd0);
      chk("rst.dout", 32'(Dout), 32'd0);
      chk("rst.flags", {err_pos, corrected, uncorrectable, crc_err}, 32'd0);
      chk("rst.cnt", 32'(corr_count), 32'd0);
      @(negedge clk); rst = 1'b0;

      xfer("zero",   32'h0000_0000, 8'h07, 0);
      xfer("fix3",   32'h0000_0004, 8'h07, 0);
      chk("fix3.pos_const", 32'(err_pos), 32'd3);
      xfer("fix21",  32'h0010_0000, 8'h07, 0);
      chk("fix21.pos_const", 32'(err_pos), 32'd21);
      xfer("unc23",  32'h0010_0002, 8'h07, 0);
      chk("unc23.cnt_const", 32'(corr_count), 32'd2);
      xfer("crc07",  32'h0000_1089, 8'h07, 20);
      chk("crc07.err_const", 32'(crc_err), 32'd1);
      xfer("crc00",  32'hFFE0_1089, 8'h00, 0);
      chk("crc00.err_const", 32'(crc_err), 32'd0);

      // Reset during CRC step 4: acceptance, CORRECT, then steps 0..3 already done
      @(negedge clk);
      Din = 32'h0000_0004; CRC_POLY = 8'h07; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1; rst = 1'b1; #1;
      chk("mid.vld", 32'(out_valid), 32'd0);
      chk("mid.rdy", 32'(in_ready), 32'd1);
      chk("mid.dout", 32'(Dout), 32'd0);
      chk("mid.flags", {err_pos, corrected, uncorrectable, crc_err}, 32'd0);
      chk("mid.cnt", 32'(corr_count), 32'd0);
      exp_cnt = 0;
      @(negedge clk); rst = 1'b0;
      aborted = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (out_valid) aborted++;
      end
      chk("mid.no_out", 32'(aborted), 32'd0);
      xfer("post", 32'h0000_0004, 8'h07, 0);

      // Random codewords with 0, 1 or 2 flipped bits
      for (int n = 0; n < 40; n++) begin
         d = 16'($urandom);
         w = encode(d) | ({$urandom} & 32'hFFE0_0000);
         case ($urandom_range(0, 2))
            1: w[$urandom_range(0, 20)] ^= 1'b1;
            2: begin
               w[$urandom_range(0, 20)] ^= 1'b1;
               w[$urandom_range(0, 20)] ^= 1'b1;
            end
            default: ;
         endcase
         xfer("rnd", w, 8'($urandom), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
